// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/MEM stages, the arbiter and the unified memory.
// master = arbiter view, slave = requesters plus memory.
interface mem_port_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic [DW-1:0] if_rdata;
   logic          if_done;

   logic          dm_req;
   logic          dm_we;
   logic [AW-1:0] dm_addr;
   logic [DW-1:0] dm_wdata;
   logic [DW-1:0] dm_rdata;
   logic          dm_done;

   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_ready;

   logic          sel;

   modport master (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
      output if_rdata, if_done, dm_rdata, dm_done, mem_req, mem_we, mem_addr, mem_wdata, sel
   );

   modport slave (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
      input  if_rdata, if_done, dm_rdata, dm_done, mem_req, mem_we, mem_addr, mem_wdata, sel
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch / load-store) arbiter and sequencer for the shared memory port.
//
//   state  | meaning
//   IDLE   | no access in flight; arbitrate and latch winner at the edge
//   ACCESS | mem_req high, request fields held until mem_ready
//   RESP   | one cycle, owner's done pulse high, requests ignored
module mem_port_arbiter (
   input  logic               clk,
   input  logic               rst_n,
   mem_port_arbiter_if.master bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;
   logic   last;
   logic   any_req;
   logic   pick_dm;

   // Tie goes to whoever was not served last; last=1 means data was served last.
   always_comb begin
      any_req = bus.if_req | bus.dm_req;
      pick_dm = bus.dm_req & (~bus.if_req | ~last);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (any_req) state_nxt = ACCESS;
         ACCESS:  if (bus.mem_ready) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.mem_req = (state == ACCESS);
      bus.if_done = (state == RESP) & ~bus.sel;
      bus.dm_done = (state == RESP) & bus.sel;
   end

   // Request fields are sampled only at the grant edge and then held until the next grant.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus.mem_addr  <= '0;
         bus.mem_we    <= 1'b0;
         bus.mem_wdata <= '0;
         bus.sel       <= 1'b0;
         bus.if_rdata  <= '0;
         bus.dm_rdata  <= '0;
         last          <= 1'b1;
      end else begin
         if (state == IDLE && any_req) begin
            bus.sel <= pick_dm;
            if (pick_dm) begin
               bus.mem_addr  <= bus.dm_addr;
               bus.mem_we    <= bus.dm_we;
               bus.mem_wdata <= bus.dm_wdata;
            end else begin
               bus.mem_addr  <= bus.if_addr;
               bus.mem_we    <= 1'b0;
               bus.mem_wdata <= '0;
            end
         end
         if (state == ACCESS && bus.mem_ready) begin
            last <= bus.sel;
            if (!bus.mem_we) begin
               if (bus.sel) begin
                  bus.dm_rdata <= bus.mem_rdata;
               end else begin
                  bus.if_rdata <= bus.mem_rdata;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: transaction-level reference plus literal pins.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

   mem_port_arbiter dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Memory responder: ready after wait_states stall cycles; optional spurious ready when idle.
   int          wait_states = 0;
   int          ws_cnt = 0;
   bit          spurious = 0;
   logic [31:0] mem_data = '0;

   always @(negedge clk) begin
      #1;
      bus.mem_rdata = mem_data;
      if (bus.mem_req === 1'b1) begin
         if (ws_cnt >= wait_states) begin
            bus.mem_ready = 1'b1;
         end else begin
            bus.mem_ready = 1'b0;
            ws_cnt++;
         end
      end else begin
         ws_cnt = 0;
         bus.mem_ready = spurious;
      end
   end

   // Reference: one access at a time; a finished access owns the next cycle for its done.
   bit          m_valid = 0;
   bit          m_busy, m_resp, m_sel, m_last, m_we;
   logic [31:0] m_addr, m_wdata, m_if_rdata, m_dm_rdata;
   bit          take_dm;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_valid = 1; m_busy = 0; m_resp = 0; m_sel = 0; m_last = 1; m_we = 0;
         m_addr = 0; m_wdata = 0; m_if_rdata = 0; m_dm_rdata = 0;
      end else if (m_valid) begin
         if (m_resp) begin
            m_resp = 0;
         end else if (m_busy) begin
            if (bus.mem_ready) begin
               if (!m_we) begin
                  if (m_sel) m_dm_rdata = bus.mem_rdata;
                  else       m_if_rdata = bus.mem_rdata;
               end
               m_last = m_sel;
               m_busy = 0;
               m_resp = 1;
            end
         end else if (bus.if_req || bus.dm_req) begin
            take_dm = bus.dm_req && !(bus.if_req && m_last);
            m_sel   = take_dm;
            m_addr  = take_dm ? bus.dm_addr  : bus.if_addr;
            m_we    = take_dm ? bus.dm_we    : 1'b0;
            m_wdata = take_dm ? bus.dm_wdata : 32'h0;
            m_busy  = 1;
         end
      end
   end

   int cyc = 0;
   int mreq_cycles = 0;
   int done_owner[$];
   int done_cyc[$];

   always @(negedge clk) begin
      cyc++;
      if (m_valid) begin
         chk("mem_req",   32'(bus.mem_req),  32'(m_busy));
         chk("mem_we",    32'(bus.mem_we),   32'(m_we));
         chk("mem_addr",  bus.mem_addr,      m_addr);
         chk("mem_wdata", bus.mem_wdata,     m_wdata);
         chk("sel",       32'(bus.sel),      32'(m_sel));
         chk("if_done",   32'(bus.if_done),  32'(m_resp && !m_sel));
         chk("dm_done",   32'(bus.dm_done),  32'(m_resp && m_sel));
         chk("if_rdata",  bus.if_rdata,      m_if_rdata);
         chk("dm_rdata",  bus.dm_rdata,      m_dm_rdata);
      end
      if (bus.mem_req === 1'b1) mreq_cycles++;
      if (bus.if_done === 1'b1) begin done_owner.push_back(0); done_cyc.push_back(cyc); end
      if (bus.dm_done === 1'b1) begin done_owner.push_back(1); done_cyc.push_back(cyc); end
   end

   // Issue one request, scramble its inputs after the grant, drop it in the done cycle.
   task automatic run_txn(input bit dm, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata, input int ws,
                          output int c0, output int mreq0);
      bit ok;
      @(negedge clk); #2;
      c0 = cyc; mreq0 = mreq_cycles;
      mem_data = rdata; wait_states = ws;
      if (dm) begin
         bus.dm_req = 1; bus.dm_we = we; bus.dm_addr = addr; bus.dm_wdata = wdata;
      end else begin
         bus.if_req = 1; bus.if_addr = addr;
      end
      ok = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (bus.if_done === 1'b1 || bus.dm_done === 1'b1) begin ok = 1; break; end
         if (i == 0) begin
            chk("grant_addr", bus.mem_addr, addr);
            chk("grant_we",   32'(bus.mem_we), 32'(we));
            chk("grant_sel",  32'(bus.sel), 32'(dm));
            #2;
            bus.if_addr = ~addr; bus.dm_addr = ~addr; bus.dm_wdata = ~wdata; bus.dm_we = ~we;
         end
      end
      #2;
      bus.if_req = 0; bus.dm_req = 0;
      chk("txn_done_seen", 32'(ok), 32'd1);
   endtask

   task automatic tie_run(input int n, input logic [31:0] rdata);
      int seen, base;
      base = done_owner.size();
      mem_data = rdata; wait_states = 0;
      bus.if_req = 1; bus.if_addr = 32'h0000_0100;
      bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h1000_0200; bus.dm_wdata = 0;
      seen = 0;
      for (int i = 0; i < 20 * n && seen < n; i++) begin
         @(negedge clk);
         if (bus.if_done === 1'b1 || bus.dm_done === 1'b1) seen++;
      end
      #2;
      bus.if_req = 0; bus.dm_req = 0;
      chk("tie_count", seen, n);
      for (int k = 0; k < n; k++) begin
         if (base + k < done_owner.size()) begin
            chk("tie_order", done_owner[base + k], k % 2);
            if (k > 0) chk("tie_gap", done_cyc[base + k] - done_cyc[base + k - 1], 3);
         end
      end
   endtask

   int c0, m0, nd;

   initial begin
      rst_n = 0;
      bus.if_req = 0; bus.if_addr = 0;
      bus.dm_req = 0; bus.dm_we = 0; bus.dm_addr = 0; bus.dm_wdata = 0;
      bus.mem_rdata = 0; bus.mem_ready = 0;
      repeat (2) @(posedge clk);
      @(negedge clk); #2;
      chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
      chk("rst_sel",     32'(bus.sel), 32'd0);
      chk("rst_if_rdata", bus.if_rdata, 32'h0);
      chk("rst_dm_rdata", bus.dm_rdata, 32'h0);
      rst_n = 1;

      // single zero-wait fetch
      run_txn(0, 0, 32'h0000_0040, 32'h0, 32'h2008_0005, 0, c0, m0);
      chk("fetch_rdata", bus.if_rdata, 32'h2008_0005);
      chk("fetch_mreq_cycles", mreq_cycles - m0, 1);
      chk("fetch_latency", done_cyc[done_cyc.size() - 1] - c0, 2);

      // store with three wait states
      nd = done_owner.size();
      run_txn(1, 1, 32'h1000_0000, 32'hDEAD_BEEF, 32'h5555_5555, 3, c0, m0);
      chk("store_mreq_cycles", mreq_cycles - m0, 4);
      chk("store_latency", done_cyc[done_cyc.size() - 1] - c0, 5);
      chk("store_dm_rdata", bus.dm_rdata, 32'h0);
      repeat (3) @(negedge clk);
      #2;
      chk("store_done_once", done_owner.size() - nd, 1);

      // load then idle: no second access
      run_txn(1, 0, 32'h2000_0010, 32'h0, 32'h0000_00FF, 0, c0, m0);
      repeat (4) @(negedge clk);
      #2;
      chk("load_dm_rdata", bus.dm_rdata, 32'h0000_00FF);
      chk("load_if_untouched", bus.if_rdata, 32'h2008_0005);
      chk("load_single_access", mreq_cycles - m0, 1);

      // spurious mem_ready in IDLE and RESP
      spurious = 1; mem_data = 32'hBAD0_BAD0;
      nd = done_owner.size(); m0 = mreq_cycles;
      repeat (4) @(negedge clk);
      #2;
      chk("spur_idle_no_done", done_owner.size() - nd, 0);
      chk("spur_idle_no_req", mreq_cycles - m0, 0);
      chk("spur_idle_if_rdata", bus.if_rdata, 32'h2008_0005);
      run_txn(0, 0, 32'h0000_0080, 32'h0, 32'h1234_5678, 0, c0, m0);
      mem_data = 32'hBAD1_BAD1;
      repeat (3) @(negedge clk);
      #2;
      spurious = 0;
      chk("spur_if_rdata", bus.if_rdata, 32'h1234_5678);
      chk("spur_dm_rdata", bus.dm_rdata, 32'h0000_00FF);
      chk("spur_one_access", mreq_cycles - m0, 1);

      // simultaneous requests right after reset
      rst_n = 0;
      repeat (2) @(negedge clk);
      #2;
      rst_n = 1;
      tie_run(4, 32'hA5A5_0001);

      // reset during a stalled access
      @(negedge clk); #2;
      bus.if_req = 1; bus.if_addr = 32'h0000_0300; wait_states = 50;
      repeat (2) @(negedge clk);
      #2;
      chk("pre_rst_mem_req", 32'(bus.mem_req), 32'd1);
      nd = done_owner.size();
      rst_n = 0;
      @(negedge clk); #2;
      bus.if_req = 0;
      chk("abort_mem_req",  32'(bus.mem_req), 32'd0);
      chk("abort_if_rdata", bus.if_rdata, 32'h0);
      chk("abort_mem_addr", bus.mem_addr, 32'h0);
      @(negedge clk); #2;
      chk("abort_no_done", done_owner.size() - nd, 0);
      rst_n = 1;
      tie_run(2, 32'hA5A5_0002);

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and sequencer for the single shared memory port of the MIPS core. The instruction-fetch unit and the load/store unit each raise a request. The block grants one at a time, drives the select of the address/data mux in front of memory, and runs a ready-based handshake with memory. It sits between the fetch/MEM stages and the unified memory and returns read data and a one-cycle done pulse to the granted requester.

## Interface
- AW, 32, address width
- DW, 32, data width

- clk  in  1  rising-edge clock, the only clock
- rst_n  in  1  synchronous, active-low reset
- if_req  in  1  fetch request, level, held until if_done
- if_addr  in  AW  fetch address
- if_rdata  out  DW  fetched word, registered
- if_done  out  1  one-cycle pulse: fetch complete
- dm_req  in  1  data request, level, held until dm_done
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  AW  data address
- dm_wdata  in  DW  store data
- dm_rdata  out  DW  load result, registered
- dm_done  out  1  one-cycle pulse: data access complete
- mem_req  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address, latched
- mem_wdata  out  DW  memory write data, latched
- mem_rdata  in  DW  memory read data, valid when mem_ready=1
- mem_ready  in  1  memory completes the current access this cycle
- sel  out  1  mux select owner: 0 = fetch, 1 = data

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If no request is present, stay in IDLE.
  - If only one request is present, grant that requester.
  - If both are present, grant the requester not served last. The `last` register resets to 1 (data), so the first tie grants fetch.
  - On grant: latch addr, we (we = 0 for fetch) and wdata from the winner into mem_addr/mem_we/mem_wdata; set sel; set mem_req=1; go to ACCESS.
- ACCESS:
  - mem_req stays 1 and mem_addr/mem_we/mem_wdata/sel stay stable until mem_ready is sampled 1.
  - On mem_ready=1 for a read (fetch, or load): capture mem_rdata into if_rdata or dm_rdata.
  - Stores leave dm_rdata unchanged.
  - On the same edge: mem_req←0, pulse the owner's done, update `last`, go to RESP.
- RESP:
  - Lasts exactly one cycle. The done pulse is high here.
  - Requests are ignored in this state.
  - Go to IDLE.
- Requester rules:
  - A requester must deassert req by the cycle after its done pulse, unless it is intentionally issuing a new request.
  - Any req seen high in IDLE is treated as a new transaction.
- Request inputs (addr/we/wdata) are sampled only at the grant edge. Later changes have no effect on the access in flight.
- mem_ready is ignored in IDLE and RESP.
- sel is registered and changes only at a grant. It holds its value through IDLE.

## Timing
- Reset values (rst_n=0 sampled at a rising edge): state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, if_rdata=0, dm_rdata=0, if_done=0, dm_done=0, sel=0, last=1.
- Reset in the middle of a transaction aborts it. No done pulse is issued and rdata is not updated.
- Cycle sequence from a request in an IDLE cycle t:
  - mem_req=1 in cycle t+1.
  - If mem_ready=1 in cycle t+1, done=1 and rdata valid in cycle t+2.
  - IDLE again in cycle t+3.
- Minimum transaction length is 3 cycles. Each extra cycle with mem_ready=0 adds one cycle.
- Back-to-back: a request held or raised in the IDLE cycle after RESP is granted at that edge.
- if_done and dm_done are never high in the same cycle.
- mem_req is high only in ACCESS.

## Test plan
- Single fetch: if_req=1, if_addr=0x0000_0040; memory returns 0x2008_0005 with mem_ready in the first ACCESS cycle. Required: mem_req high exactly 1 cycle, sel=0, if_done one cycle later, if_rdata=0x2008_0005, total 3 cycles.
- Store with wait states: dm_we=1, dm_addr=0x1000_0000, dm_wdata=0xDEAD_BEEF; mem_ready delayed 3 cycles. Required: mem_we=1, address and data stable for 4 ACCESS cycles, sel=1, dm_done pulses once, dm_rdata unchanged.
- Simultaneous requests right after reset, both held: grant order must be fetch, data, fetch, data. Each done arrives 3 cycles after the previous one when memory is zero-wait.
- Load then idle: dm_req dropped in the cycle after dm_done. Required: no second access. Load data 0x0000_00FF appears on dm_rdata, and if_rdata is untouched.
- Spurious mem_ready=1 in IDLE and in RESP: required no state change, no done, no rdata change.
- Reset asserted during ACCESS with mem_ready=0: required next cycle IDLE, mem_req=0, no done pulse, all outputs at reset values. The first tie after reset grants fetch.
